// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data-memory FSM encodings, timeout default
// and the request payload held on the data-memory bus.
package mips_pkg;

    localparam int unsigned DMEM_TIMEOUT = 16;
    localparam int unsigned DMEM_CNT_W   = 5;
    localparam int unsigned XLEN         = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Wait-cycle counter for data-memory accesses; tc_o flags the last allowed cycle.
module dmem_timeout_cnt #(
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned TERMINAL = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(TERMINAL));

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues req/ack accesses, stalls and bubbles the
// pipeline while busy, and reports misaligned and timed-out accesses.
module dmem_access_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT,
    parameter int unsigned CNT_W          = DMEM_CNT_W
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            I_MemRead,
    input  logic            I_MemWrite,
    input  logic [XLEN-1:0] I_ADDR,
    input  logic [XLEN-1:0] I_WDATA,
    output logic            O_DMEM_REQ,
    output logic            O_DMEM_WE,
    output logic [XLEN-1:0] O_DMEM_ADDR,
    output logic [XLEN-1:0] O_DMEM_WDATA,
    input  logic            I_DMEM_ACK,
    input  logic [XLEN-1:0] I_DMEM_RDATA,
    output logic [XLEN-1:0] O_READDATA,
    output logic            O_STALL,
    output logic            O_MEMWB_BUBBLE,
    output logic            O_ALIGN_ERR,
    output logic            O_BUS_ERR
);

    logic [1:0]      state_q, state_d;
    logic            req_q, req_d;
    dmem_req_t       dreq_q, dreq_d;
    logic [XLEN-1:0] readdata_q, readdata_d;
    logic            access;
    logic            cnt_clr;
    logic            cnt_en;
    logic            cnt_tc;

    assign access = I_MemRead | I_MemWrite;

    dmem_timeout_cnt #(
        .CNT_W    (CNT_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timeout_cnt (
        .clk_i (CLK),
        .rst_i (RESET),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // Next-state, memory-side register updates and pipeline control decode
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        dreq_d         = dreq_q;
        readdata_d     = readdata_q;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;
        O_STALL        = 1'b0;
        O_MEMWB_BUBBLE = 1'b0;
        O_ALIGN_ERR    = 1'b0;
        O_BUS_ERR      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    O_MEMWB_BUBBLE = 1'b1;
                    if (I_ADDR[1:0] != 2'b00) begin
                        O_ALIGN_ERR = 1'b1;
                    end else begin
                        O_STALL      = 1'b1;
                        req_d        = 1'b1;
                        dreq_d.we    = I_MemWrite;
                        dreq_d.addr  = {I_ADDR[XLEN-1:2], 2'b00};
                        dreq_d.wdata = I_WDATA;
                        state_d      = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                O_STALL        = 1'b1;
                O_MEMWB_BUBBLE = 1'b1;
                // An ACK on the terminal cycle still completes the access
                if (I_DMEM_ACK) begin
                    if (!dreq_q.we) begin
                        readdata_d = I_DMEM_RDATA;
                    end
                    req_d     = 1'b0;
                    dreq_d.we = 1'b0;
                    state_d   = ST_DONE;
                end else if (cnt_tc) begin
                    req_d     = 1'b0;
                    dreq_d.we = 1'b0;
                    state_d   = ST_ERR;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                O_BUS_ERR      = 1'b1;
                O_MEMWB_BUBBLE = 1'b1;
                cnt_clr        = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            dreq_q     <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            dreq_q     <= dreq_d;
            readdata_q <= readdata_d;
        end
    end

    assign O_DMEM_REQ   = req_q;
    assign O_DMEM_WE    = dreq_q.we;
    assign O_DMEM_ADDR  = dreq_q.addr;
    assign O_DMEM_WDATA = dreq_q.wdata;
    assign O_READDATA   = readdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Cycle-by-cycle vector bench for dmem_access_ctrl with a scoreboard queue of
// expected outputs popped on the falling edge.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] readdata;
    logic        stall;
    logic        bubble;
    logic        align_err;
    logic        bus_err;

    dmem_access_ctrl #(
        .TIMEOUT_CYCLES (16),
        .CNT_W          (5)
    ) dut (
        .CLK            (clk),
        .RESET          (rst),
        .I_MemRead      (mem_read),
        .I_MemWrite     (mem_write),
        .I_ADDR         (addr),
        .I_WDATA        (wdata),
        .O_DMEM_REQ     (dmem_req),
        .O_DMEM_WE      (dmem_we),
        .O_DMEM_ADDR    (dmem_addr),
        .O_DMEM_WDATA   (dmem_wdata),
        .I_DMEM_ACK     (dmem_ack),
        .I_DMEM_RDATA   (dmem_rdata),
        .O_READDATA     (readdata),
        .O_STALL        (stall),
        .O_MEMWB_BUBBLE (bubble),
        .O_ALIGN_ERR    (align_err),
        .O_BUS_ERR      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        chk;
        logic        rst, rd, wr, ack;
        logic [31:0] addr, wdata, rdata;
        logic        req, we, stall, bub, aerr, berr;
        logic [31:0] maddr, mwdata, rdout;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic rd, input logic wr, input logic ack,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                       input logic req, input logic we, input logic st, input logic bub,
                       input logic aerr, input logic berr,
                       input logic [31:0] maddr, input logic [31:0] mwdata,
                       input logic [31:0] rdout);
        vec_t t;
        t.id = vecs.size(); t.chk = 1'b1;
        t.rst = r; t.rd = rd; t.wr = wr; t.ack = ack;
        t.addr = a; t.wdata = wd; t.rdata = rdat;
        t.req = req; t.we = we; t.stall = st; t.bub = bub; t.aerr = aerr; t.berr = berr;
        t.maddr = maddr; t.mwdata = mwdata; t.rdout = rdout;
        vecs.push_back(t);
    endtask

    task automatic idle(input logic [31:0] rdout);
        add(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, rdout);
    endtask

    task automatic start(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdout);
        add(0, rd, wr, 0, a, wd, 32'h0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h0, rdout);
    endtask

    task automatic wcyc(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic ack, input logic [31:0] rdat,
                        input logic [31:0] rdout);
        add(0, rd, wr, ack, a, wd, rdat, 1, wr, 1, 1, 0, 0, a, wd, rdout);
    endtask

    task automatic done(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdout);
        add(0, rd, wr, 0, a, wd, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, rdout);
    endtask

    task automatic cmp(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Scoreboard check, sampled mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                cmp("req",      e.id, 32'(dmem_req),  32'(e.req));
                cmp("we",       e.id, 32'(dmem_we),   32'(e.we));
                cmp("stall",    e.id, 32'(stall),     32'(e.stall));
                cmp("bubble",   e.id, 32'(bubble),    32'(e.bub));
                cmp("align_err", e.id, 32'(align_err), 32'(e.aerr));
                cmp("bus_err",  e.id, 32'(bus_err),   32'(e.berr));
                cmp("readdata", e.id, readdata,       e.rdout);
                if (e.req) cmp("dmem_addr", e.id, dmem_addr, e.maddr);
                if (e.req && e.we) cmp("dmem_wdata", e.id, dmem_wdata, e.mwdata);
            end
        end
    end

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;

        // Reset, then idle with everything cleared
        add(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        vecs[vecs.size()-1].chk = 1'b0;
        idle(32'h0);

        // Load 0x100, ACK in first WAIT cycle
        start(1, 0, 32'h100, 32'h0, 32'h0);
        wcyc(1, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 32'h0);
        done(1, 0, 32'h100, 32'h0, 32'hDEADBEEF);
        idle(32'hDEADBEEF);

        // Store 0x204, five WAIT cycles; returned data must not reach O_READDATA
        start(0, 1, 32'h204, 32'h12345678, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) wcyc(0, 1, 32'h204, 32'h12345678, 0, 32'h0, 32'hDEADBEEF);
        wcyc(0, 1, 32'h204, 32'h12345678, 1, 32'hBAD0BAD0, 32'hDEADBEEF);
        done(0, 1, 32'h204, 32'h12345678, 32'hDEADBEEF);
        idle(32'hDEADBEEF);

        // Misaligned load and misaligned read+write
        add(0, 1, 0, 0, 32'h102, 32'h0, 32'h0, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'hDEADBEEF);
        idle(32'hDEADBEEF);
        add(0, 1, 1, 0, 32'h203, 32'h5, 32'h0, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'hDEADBEEF);
        idle(32'hDEADBEEF);

        // Load with no ACK: 16 REQ cycles then ERR
        start(1, 0, 32'h300, 32'h0, 32'hDEADBEEF);
        for (int i = 0; i < 16; i++) wcyc(1, 0, 32'h300, 32'h0, 0, 32'h0, 32'hDEADBEEF);
        add(0, 1, 0, 0, 32'h300, 32'h0, 32'h0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0, 32'hDEADBEEF);
        idle(32'hDEADBEEF);

        // ACK on the terminal WAIT cycle completes normally
        start(1, 0, 32'h304, 32'h0, 32'hDEADBEEF);
        for (int i = 0; i < 15; i++) wcyc(1, 0, 32'h304, 32'h0, 0, 32'h0, 32'hDEADBEEF);
        wcyc(1, 0, 32'h304, 32'h0, 1, 32'hCAFEF00D, 32'hDEADBEEF);
        done(1, 0, 32'h304, 32'h0, 32'hCAFEF00D);
        idle(32'hCAFEF00D);

        // Reset during WAIT, then a stray ACK in IDLE
        start(1, 0, 32'h400, 32'h0, 32'hCAFEF00D);
        wcyc(1, 0, 32'h400, 32'h0, 0, 32'h0, 32'hCAFEF00D);
        add(1, 1, 0, 0, 32'h400, 32'h0, 32'h0, 1, 0, 1, 1, 0, 0, 32'h400, 32'h0, 32'hCAFEF00D);
        idle(32'h0);
        add(0, 0, 0, 1, 32'h0, 32'h0, 32'h11111111, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        idle(32'h0);

        // Back-to-back loads; the completed one on the inputs in DONE is not reissued
        start(1, 0, 32'h500, 32'h0, 32'h0);
        wcyc(1, 0, 32'h500, 32'h0, 1, 32'hA1A1A1A1, 32'h0);
        done(1, 0, 32'h500, 32'h0, 32'hA1A1A1A1);
        start(1, 0, 32'h504, 32'h0, 32'hA1A1A1A1);
        wcyc(1, 0, 32'h504, 32'h0, 1, 32'hA2A2A2A2, 32'hA1A1A1A1);
        done(1, 0, 32'h504, 32'h0, 32'hA2A2A2A2);
        idle(32'hA2A2A2A2);
        idle(32'hA2A2A2A2);

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            rst        = vecs[k].rst;
            mem_read   = vecs[k].rd;
            mem_write  = vecs[k].wr;
            addr       = vecs[k].addr;
            wdata      = vecs[k].wdata;
            dmem_ack   = vecs[k].ack;
            dmem_rdata = vecs[k].rdata;
            sb.push_back(vecs[k]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0;
        @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
